expr_checker: RTL

Byte-serial recogniser that validates an arithmetic expression, one ASCII character per accepted clock, over the grammar expr := term (op term)*, term := number | '(' expr ')'. It is the parametrised successor of the single-digit "digit op digit" string recogniser, adding:
- multi-digit numbers, four operators, nested parentheses, optional blank skipping;
- a valid-qualified input and a sticky error flag.

It sits after the character source in the lab datapath and drives a pass/fail indicator.

---
 rtl/expr_checker.sv | 74 +++++++
 1 files changed

// File: rtl/expr_checker.sv
// expr_checker: byte-serial recogniser for expr := term (op term)*, term := number | '(' expr ')'
module expr_checker #(
  parameter int MAX_DIGITS = 4,
  parameter int DEPTH_W    = 3,
  parameter int SKIP_SPACE = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);
  typedef enum logic [1:0] {EXP_OPND, IN_NUM, AFTER_OPND, ERR} state_t;
  localparam logic [DEPTH_W-1:0] DMAX = '1;
  localparam logic [3:0] DLIM = 4'(MAX_DIGITS);
  state_t state, state_n;
  logic [DEPTH_W-1:0] depth_n;
  logic [3:0] dcnt, dcnt_n;
  logic is_digit, is_op, is_lpar, is_rpar, is_sp;
  assign is_digit = in >= 8'h30 && in <= 8'h39;
  assign is_op    = in == 8'h2b || in == 8'h2d || in == 8'h2a || in == 8'h2f;
  assign is_lpar  = in == 8'h28;
  assign is_rpar  = in == 8'h29;
  assign is_sp    = SKIP_SPACE != 0 && in == 8'h20;
  always_comb begin
    state_n = state;
    depth_n = depth;
    dcnt_n  = dcnt;
    if (in_valid)
      case (state)
        EXP_OPND:
          if (is_digit) begin
            state_n = IN_NUM;
            dcnt_n  = 4'd1;
          end else if (is_lpar) begin
            if (depth != DMAX) depth_n = depth + 1'b1;
            else state_n = ERR;
          end else if (!is_sp) state_n = ERR;
        IN_NUM:
          if (is_digit) begin
            if (dcnt < DLIM) dcnt_n = dcnt + 4'd1;
            else state_n = ERR;
          end else if (is_op) state_n = EXP_OPND;
          else if (is_rpar) begin
            if (depth != '0) begin
              depth_n = depth - 1'b1;
              state_n = AFTER_OPND;
            end else state_n = ERR;
          end else if (is_sp) state_n = AFTER_OPND;
          else state_n = ERR;
        AFTER_OPND:
          if (is_op) state_n = EXP_OPND;
          else if (is_rpar) begin
            if (depth != '0) depth_n = depth - 1'b1;
            else state_n = ERR;
          end else if (!is_sp) state_n = ERR;
        default: state_n = ERR;
      endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= EXP_OPND;
      depth <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      depth <= depth_n;
      dcnt  <= dcnt_n;
    end
  assign out = (state == IN_NUM || state == AFTER_OPND) && depth == '0;
  assign err = state == ERR;
endmodule
